// File: rtl/stack_arbiter_if.sv
// Bundle of requester handshakes and stack-side strobes/flags for stack_arbiter.
// The slave modport is the arbiter's view; master is the requester/stack side.
interface stack_arbiter_if #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic                  REQ_A;
  logic                  REQ_B;
  logic                  OP_A;
  logic                  OP_B;
  logic [DATA_WIDTH-1:0] WDATA_A;
  logic [DATA_WIDTH-1:0] WDATA_B;
  logic                  ACK_A;
  logic                  ACK_B;
  logic                  ERR_A;
  logic                  ERR_B;
  logic [DATA_WIDTH-1:0] RDATA_A;
  logic [DATA_WIDTH-1:0] RDATA_B;
  logic                  STK_PUSH;
  logic                  STK_POP;
  logic [DATA_WIDTH-1:0] STK_DATA_IN;
  logic [DATA_WIDTH-1:0] STK_DATA_OUT;
  logic                  STK_FULL;
  logic                  STK_EMPTY;
  logic [LEVEL_W-1:0]    LEVEL;

  modport slave (
    input  REQ_A, REQ_B, OP_A, OP_B, WDATA_A, WDATA_B,
    input  STK_DATA_OUT, STK_FULL, STK_EMPTY,
    output ACK_A, ACK_B, ERR_A, ERR_B, RDATA_A, RDATA_B,
    output STK_PUSH, STK_POP, STK_DATA_IN, LEVEL
  );

  modport master (
    output REQ_A, REQ_B, OP_A, OP_B, WDATA_A, WDATA_B,
    output STK_DATA_OUT, STK_FULL, STK_EMPTY,
    input  ACK_A, ACK_B, ERR_A, ERR_B, RDATA_A, RDATA_B,
    input  STK_PUSH, STK_POP, STK_DATA_IN, LEVEL
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin two-port arbiter that sequences one push/pop at a time onto a
// shared stack, with fixed 3-cycle grant-to-ack latency and occupancy tracking.
module stack_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16
) (
  input  logic            CLK,
  input  logic            RST,
  stack_arbiter_if.slave  bus
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic                  op_q, op_d;
  logic                  reject_q, reject_d;
  logic                  stk_push_q, stk_push_d;
  logic                  stk_pop_q, stk_pop_d;
  logic [DATA_WIDTH-1:0] stk_data_in_q, stk_data_in_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic                  ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic                  err_a_q, err_a_d, err_b_q, err_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

  logic                  grant_b_s;
  logic                  win_op_s;
  logic                  win_reject_s;
  logic [DATA_WIDTH-1:0] win_wdata_s;
  logic [DATA_WIDTH-1:0] result_s;

  // Next-state, grant selection and registered-output computation.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    port_d        = port_q;
    op_d          = op_q;
    reject_d      = reject_q;
    stk_push_d    = 1'b0;
    stk_pop_d     = 1'b0;
    stk_data_in_d = stk_data_in_q;
    level_d       = level_q;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    err_a_d       = 1'b0;
    err_b_d       = 1'b0;
    rdata_a_d     = rdata_a_q;
    rdata_b_d     = rdata_b_q;

    // B wins only if A is idle or A was granted last; LAST resets to B so A wins the first tie.
    grant_b_s    = bus.REQ_B && (!bus.REQ_A || (last_q == PORT_A));
    win_op_s     = grant_b_s ? bus.OP_B : bus.OP_A;
    win_wdata_s  = grant_b_s ? bus.WDATA_B : bus.WDATA_A;
    win_reject_s = (win_op_s && bus.STK_FULL) || (!win_op_s && bus.STK_EMPTY);
    result_s     = reject_q ? {DATA_WIDTH{1'b0}} : bus.STK_DATA_OUT;

    case (state_q)
      S_IDLE: begin
        if (bus.REQ_A || bus.REQ_B) begin
          state_d       = S_ISSUE;
          last_d        = grant_b_s;
          port_d        = grant_b_s;
          op_d          = win_op_s;
          reject_d      = win_reject_s;
          stk_data_in_d = win_wdata_s;
          stk_push_d    = win_op_s && !win_reject_s;
          stk_pop_d     = !win_op_s && !win_reject_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        if (reject_q) begin
          level_d = level_q;
        end else if (op_q) begin
          level_d = level_q + LEVEL_W'(1);
        end else begin
          level_d = level_q - LEVEL_W'(1);
        end
      end
      S_WAIT: begin
        state_d = S_RESP;
        if (port_q == PORT_B) begin
          ack_b_d   = 1'b1;
          err_b_d   = reject_q;
          rdata_b_d = result_s;
        end else begin
          ack_a_d   = 1'b1;
          err_a_d   = reject_q;
          rdata_a_d = result_s;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      last_q        <= PORT_B;
      port_q        <= PORT_A;
      op_q          <= 1'b0;
      reject_q      <= 1'b0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= {DATA_WIDTH{1'b0}};
      level_q       <= {LEVEL_W{1'b0}};
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      err_a_q       <= 1'b0;
      err_b_q       <= 1'b0;
      rdata_a_q     <= {DATA_WIDTH{1'b0}};
      rdata_b_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      port_q        <= port_d;
      op_q          <= op_d;
      reject_q      <= reject_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
      level_q       <= level_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      err_a_q       <= err_a_d;
      err_b_q       <= err_b_d;
      rdata_a_q     <= rdata_a_d;
      rdata_b_q     <= rdata_b_d;
    end
  end

  assign bus.ACK_A       = ack_a_q;
  assign bus.ACK_B       = ack_b_q;
  assign bus.ERR_A       = err_a_q;
  assign bus.ERR_B       = err_b_q;
  assign bus.RDATA_A     = rdata_a_q;
  assign bus.RDATA_B     = rdata_b_q;
  assign bus.STK_PUSH    = stk_push_q;
  assign bus.STK_POP     = stk_pop_q;
  assign bus.STK_DATA_IN = stk_data_in_q;
  assign bus.LEVEL       = level_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed self-checking bench for stack_arbiter with a small behavioural
// stack (DATA_WIDTH=2, DEPTH=4) on the stack side.
module tb_stack_arbiter;
  logic CLK;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;
  int   push_cnt = 0;
  int   pop_cnt = 0;
  int   both_cnt = 0;
  int   ack_cnt = 0;

  stack_arbiter_if #(.DATA_WIDTH(2), .DEPTH(4)) bus ();

  stack_arbiter #(.DATA_WIDTH(2), .DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural stack: registered DATA_OUT shows the pushed value, or the popped value.
  logic [1:0] mem [0:3];
  logic [2:0] sp;
  logic [1:0] dout;
  logic [2:0] sp_m1;
  assign sp_m1 = sp - 3'd1;
  always @(posedge CLK) begin
    if (RST) begin
      sp   <= 3'd0;
      dout <= 2'b00;
    end else if (bus.STK_PUSH && (sp < 3'd4)) begin
      mem[sp[1:0]] <= bus.STK_DATA_IN;
      sp           <= sp + 3'd1;
      dout         <= bus.STK_DATA_IN;
    end else if (bus.STK_POP && (sp != 3'd0)) begin
      sp   <= sp_m1;
      dout <= mem[sp_m1[1:0]];
    end
  end
  assign bus.STK_FULL     = (sp == 3'd4);
  assign bus.STK_EMPTY    = (sp == 3'd0);
  assign bus.STK_DATA_OUT = dout;

  // Event counters sampled mid-cycle.
  always @(negedge CLK) begin
    if (bus.STK_PUSH === 1'b1) push_cnt <= push_cnt + 1;
    if (bus.STK_POP === 1'b1) pop_cnt <= pop_cnt + 1;
    if ((bus.STK_PUSH === 1'b1) && (bus.STK_POP === 1'b1)) both_cnt <= both_cnt + 1;
    if ((bus.ACK_A === 1'b1) || (bus.ACK_B === 1'b1)) ack_cnt <= ack_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // One request from one port; checks strobe, latency, ack fields and resulting LEVEL.
  task automatic run_op(input string tag, input bit port, input bit op, input logic [1:0] wd,
                        input bit exp_err, input logic [1:0] exp_rd, input logic [2:0] exp_lvl);
    int  push0, pop0, lat;
    bit  seen;
    logic [1:0] rd;
    @(negedge CLK);
    push0 = push_cnt;
    pop0  = pop_cnt;
    if (port) begin
      bus.REQ_B = 1'b1; bus.OP_B = op; bus.WDATA_B = wd;
    end else begin
      bus.REQ_A = 1'b1; bus.OP_A = op; bus.WDATA_A = wd;
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 10) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        check_eq({tag, "_push_strobe"}, bus.STK_PUSH, op && !exp_err);
        check_eq({tag, "_pop_strobe"}, bus.STK_POP, !op && !exp_err);
        if (op && !exp_err) check_eq({tag, "_data_in"}, bus.STK_DATA_IN, wd);
      end
      if ((port ? bus.ACK_B : bus.ACK_A) === 1'b1) begin
        seen = 1'b1;
        check_eq({tag, "_latency"}, lat, 3);
        check_eq({tag, "_other_ack"}, port ? bus.ACK_A : bus.ACK_B, 1'b0);
        check_eq({tag, "_err"}, port ? bus.ERR_B : bus.ERR_A, exp_err);
        rd = port ? bus.RDATA_B : bus.RDATA_A;
        check_eq({tag, "_rdata"}, rd, exp_rd);
        bus.REQ_A = 1'b0;
        bus.REQ_B = 1'b0;
      end
    end
    check_eq({tag, "_ack_seen"}, seen, 1'b1);
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
    @(negedge CLK);
    check_eq({tag, "_ack_pulse"}, port ? bus.ACK_B : bus.ACK_A, 1'b0);
    check_eq({tag, "_rdata_hold"}, port ? bus.RDATA_B : bus.RDATA_A, exp_rd);
    check_eq({tag, "_push_count"}, push_cnt - push0, (op && !exp_err) ? 1 : 0);
    check_eq({tag, "_pop_count"}, pop_cnt - pop0, (!op && !exp_err) ? 1 : 0);
    check_eq({tag, "_level"}, bus.LEVEL, exp_lvl);
  endtask

  initial begin
    int p0, a0, cyc, last_ack, nack;
    bit exp_b;
    RST = 1'b1;
    bus.REQ_A = 1'b1; bus.OP_A = 1'b1; bus.WDATA_A = 2'b11;
    bus.REQ_B = 1'b0; bus.OP_B = 1'b0; bus.WDATA_B = 2'b00;

    // Reset with a request pending
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_ack", {bus.ACK_A, bus.ACK_B, bus.ERR_A, bus.ERR_B}, 4'b0000);
    check_eq("rst_rdata", {bus.RDATA_A, bus.RDATA_B}, 4'b0000);
    check_eq("rst_strobes", {bus.STK_PUSH, bus.STK_POP}, 2'b00);
    check_eq("rst_data_in", bus.STK_DATA_IN, 2'b00);
    check_eq("rst_level", bus.LEVEL, 3'd0);
    bus.REQ_A = 1'b0;
    RST = 1'b0;
    p0 = push_cnt + pop_cnt;
    repeat (3) @(negedge CLK);
    check_eq("rst_no_strobe", push_cnt + pop_cnt - p0, 0);

    // Single push
    run_op("single_push", 1'b0, 1'b1, 2'b10, 1'b0, 2'b10, 3'd1);

    // Contention: four pushes with both requests held
    do_reset();
    @(negedge CLK);
    bus.REQ_A = 1'b1; bus.OP_A = 1'b1; bus.WDATA_A = 2'b01;
    bus.REQ_B = 1'b1; bus.OP_B = 1'b1; bus.WDATA_B = 2'b10;
    cyc = 0; last_ack = -1; nack = 0; exp_b = 1'b0;
    while (nack < 4 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (bus.ACK_A || bus.ACK_B) begin
        check_eq("cont_overlap", bus.ACK_A & bus.ACK_B, 1'b0);
        check_eq("cont_order", bus.ACK_B, exp_b);
        check_eq("cont_rdata", exp_b ? bus.RDATA_B : bus.RDATA_A, exp_b ? 2'b10 : 2'b01);
        check_eq("cont_err", bus.ERR_A | bus.ERR_B, 1'b0);
        if (last_ack >= 0) check_eq("cont_gap", cyc - last_ack, 4);
        else check_eq("cont_first_lat", cyc, 3);
        last_ack = cyc;
        exp_b = !exp_b;
        nack++;
        if (nack == 4) begin
          bus.REQ_A = 1'b0;
          bus.REQ_B = 1'b0;
        end
      end
    end
    check_eq("cont_ack_total", nack, 4);
    bus.REQ_A = 1'b0;
    bus.REQ_B = 1'b0;
    @(negedge CLK);
    check_eq("cont_level", bus.LEVEL, 3'd4);

    // Full reject from B
    run_op("full_reject", 1'b1, 1'b1, 2'b11, 1'b1, 2'b00, 3'd4);

    // Empty reject, then push and pop
    do_reset();
    run_op("empty_reject", 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'd0);
    run_op("push01", 1'b0, 1'b1, 2'b01, 1'b0, 2'b01, 3'd1);
    run_op("pop01", 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'd0);

    // Reset during WAIT of an accepted push
    do_reset();
    @(negedge CLK);
    a0 = ack_cnt;
    bus.REQ_A = 1'b1; bus.OP_A = 1'b1; bus.WDATA_A = 2'b11;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    bus.REQ_A = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    check_eq("midrst_ack", bus.ACK_A, 1'b0);
    check_eq("midrst_level", bus.LEVEL, 3'd0);
    repeat (4) @(negedge CLK);
    check_eq("midrst_no_ack", ack_cnt - a0, 0);
    run_op("after_midrst", 1'b0, 1'b1, 2'b11, 1'b0, 2'b11, 3'd1);

    check_eq("strobe_both_high", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
